qoi_pixel_framer: RTL

QOI_PIXEL_FRAMER -- requirements
Module: qoi_pixel_framer

---
 rtl/qoi_pkg.sv | 31 +++
 rtl/qoi_beat_serializer.sv | 61 ++++++
 rtl/qoi_pixel_framer.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/qoi_pkg.sv
// qoi_pkg: shared types and constants for the QOI pixel framer.
//   state_t      - framer FSM states
//   CH_*         - channel byte positions within a pixel (R at the LSB)
//   ALPHA_OPAQUE - alpha reported for RGB-only streams
//   rgba_t       - one output pixel
//   idx_w()      - width of a pixel index into a beat (at least 1 bit)
package qoi_pkg;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_STREAM, S_PAD, S_DRAIN, S_DONE
  } state_t;

  localparam int CH_R = 0;
  localparam int CH_G = 1;
  localparam int CH_B = 2;
  localparam int CH_A = 3;

  localparam logic [7:0] ALPHA_OPAQUE = 8'hFF;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] g;
    logic [7:0] r;
  } rgba_t;

  function automatic int idx_w(input int ppb);
    return (ppb > 1) ? $clog2(ppb) : 1;
  endfunction

endpackage

// File: rtl/qoi_beat_serializer.sv
// qoi_beat_serializer: holds one input beat of PPB pixels and hands them out
// one per output handshake, pixel 0 first.
//   clk, rstn    - clock, synchronous active-low reset
//   i_load       - capture i_beat (only raised while o_ready=1)
//   i_beat       - PPB packed pixels, pixel k at [k*CH*8 +: CH*8]
//   i_last_idx   - index of the last pixel of i_beat worth emitting
//   o_ready      - register empty, or its last pixel leaves this cycle
//   i_out_ready  - downstream ready
//   o_valid      - a pixel is being offered
//   o_pix        - offered pixel (stable until it is taken)
module qoi_beat_serializer
  import qoi_pkg::*;
#(
  parameter int PPB = 2,
  parameter int CH  = 3,
  localparam int PIX_W = CH * 8,
  localparam int IDX_W = idx_w(PPB)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   i_load,
  input  logic [PPB*PIX_W-1:0]   i_beat,
  input  logic [IDX_W-1:0]       i_last_idx,
  output logic                   o_ready,
  input  logic                   i_out_ready,
  output logic                   o_valid,
  output logic [PIX_W-1:0]       o_pix
);

  logic [PPB-1:0][PIX_W-1:0] r_beat;
  logic [IDX_W-1:0]          r_idx;
  logic [IDX_W-1:0]          r_last_idx;
  logic                      r_full;
  logic                      w_hs;
  logic                      w_last;

  assign w_hs    = r_full & i_out_ready;
  assign w_last  = (r_idx == r_last_idx);
  // Refill in the same cycle the final pixel leaves: no bubble between beats.
  assign o_ready = ~r_full | (w_hs & w_last);
  assign o_valid = r_full;
  assign o_pix   = r_beat[r_idx];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_beat     <= '0;
      r_idx      <= '0;
      r_last_idx <= '0;
      r_full     <= 1'b0;
    end else if (i_load) begin
      r_beat     <= i_beat;
      r_idx      <= '0;
      r_last_idx <= i_last_idx;
      r_full     <= 1'b1;
    end else if (w_hs) begin
      if (w_last) r_full <= 1'b0;
      else        r_idx  <= r_idx + 1'b1;
    end
  end

endmodule

// File: rtl/qoi_pixel_framer.sv
// qoi_pixel_framer: frames a beat stream of PPB pixels into exactly
// width*height single pixels for a QOI compressor, padding short frames,
// draining long ones, and reporting cycle count and error flags.
//   clk, rstn                    - clock, synchronous active-low reset
//   cfg_*                        - frame request (width/height, start)
//   s_*                          - input beat stream
//   c_ctrl_*                     - compressor control (one start pulse/frame)
//   m_*                          - output pixel stream (A=FF when CH=3)
//   stat_*                       - per-frame status, valid with stat_valid
module qoi_pixel_framer
  import qoi_pkg::*;
#(
  parameter int PPB   = 2,
  parameter int CH    = 3,
  parameter int CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  output logic                  cfg_ready,
  input  logic                  cfg_start,
  input  logic [15:0]           cfg_width,
  input  logic [15:0]           cfg_height,
  output logic                  s_tready,
  input  logic                  s_tvalid,
  input  logic                  s_tlast,
  input  logic [PPB*CH*8-1:0]   s_tdata,
  input  logic                  c_ctrl_ready,
  output logic                  c_ctrl_start,
  output logic [15:0]           c_ctrl_width,
  output logic [15:0]           c_ctrl_height,
  input  logic                  m_tready,
  output logic                  m_tvalid,
  output logic                  m_tlast,
  output logic [7:0]            m_R,
  output logic [7:0]            m_G,
  output logic [7:0]            m_B,
  output logic [7:0]            m_A,
  output logic                  stat_valid,
  output logic [CNT_W-1:0]      stat_cycles,
  output logic                  stat_err_early,
  output logic                  stat_err_late,
  output logic                  stat_err_zero
);

  localparam int PIX_W = CH * 8;
  localparam int IDX_W = idx_w(PPB);

  state_t           r_state;
  logic [15:0]      r_width, r_height;
  logic [31:0]      r_total;   // pixels in the frame
  logic [31:0]      r_rcv;     // pixels received so far (whole beats)
  logic [31:0]      r_ocnt;    // pixels emitted so far
  logic             r_in_done, r_out_done;
  logic             r_err_early, r_err_late, r_err_zero;
  logic             r_ctrl_start, r_cnt_run;
  logic [CNT_W-1:0] r_cnt;
  rgba_t            r_last_pix;  // last emitted pixel, replayed while padding

  logic [31:0]      w_total, w_rem;
  logic             w_reached, w_s_hs, w_m_hs;
  logic [IDX_W-1:0] w_last_idx;
  logic             w_ser_ready, w_ser_valid;
  logic [PIX_W-1:0] w_ser_pix;
  logic [7:0]       w_alpha;
  rgba_t            w_ser_rgba, w_pix;

  assign w_total   = {16'd0, cfg_width} * {16'd0, cfg_height};
  assign w_rem     = r_total - r_rcv;
  // This beat carries the final frame pixel; later pixels in it are dropped.
  assign w_reached = (w_rem <= 32'(PPB));
  assign w_last_idx = w_reached ? IDX_W'(w_rem - 32'd1) : IDX_W'(PPB - 1);

  assign s_tready = ((r_state == S_STREAM && w_ser_ready) || r_state == S_DRAIN)
                    && !r_in_done;
  assign w_s_hs   = s_tvalid & s_tready;

  qoi_beat_serializer #(.PPB(PPB), .CH(CH)) u_ser (
    .clk        (clk),
    .rstn       (rstn),
    .i_load     (w_s_hs && r_state == S_STREAM),
    .i_beat     (s_tdata),
    .i_last_idx (w_last_idx),
    .o_ready    (w_ser_ready),
    .i_out_ready(m_tready),
    .o_valid    (w_ser_valid),
    .o_pix      (w_ser_pix)
  );

  generate
    if (CH == 4) begin : g_alpha
      assign w_alpha = w_ser_pix[CH_A*8 +: 8];
    end else begin : g_opaque
      assign w_alpha = ALPHA_OPAQUE;
    end
  endgenerate

  assign w_ser_rgba = '{a: w_alpha,
                        b: w_ser_pix[CH_B*8 +: 8],
                        g: w_ser_pix[CH_G*8 +: 8],
                        r: w_ser_pix[CH_R*8 +: 8]};

  // Buffered beat pixels go first; padding only once the register is empty.
  assign w_pix    = w_ser_valid ? w_ser_rgba : r_last_pix;
  assign m_tvalid = w_ser_valid | (r_state == S_PAD && !r_out_done);
  assign m_tlast  = m_tvalid && (r_ocnt == r_total - 32'd1);
  assign w_m_hs   = m_tvalid & m_tready;
  assign m_R      = w_pix.r;
  assign m_G      = w_pix.g;
  assign m_B      = w_pix.b;
  assign m_A      = w_pix.a;

  assign cfg_ready      = (r_state == S_IDLE);
  assign stat_valid     = (r_state == S_DONE);
  assign stat_cycles    = r_cnt;
  assign stat_err_early = r_err_early;
  assign stat_err_late  = r_err_late;
  assign stat_err_zero  = r_err_zero;
  assign c_ctrl_start   = r_ctrl_start;
  assign c_ctrl_width   = r_width;
  assign c_ctrl_height  = r_height;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state      <= S_IDLE;
      r_width      <= '0;
      r_height     <= '0;
      r_total      <= '0;
      r_rcv        <= '0;
      r_ocnt       <= '0;
      r_in_done    <= 1'b0;
      r_out_done   <= 1'b0;
      r_err_early  <= 1'b0;
      r_err_late   <= 1'b0;
      r_err_zero   <= 1'b0;
      r_ctrl_start <= 1'b0;
      r_cnt_run    <= 1'b0;
      r_cnt        <= '0;
      r_last_pix   <= {ALPHA_OPAQUE, 24'd0};
    end else begin
      r_ctrl_start <= 1'b0;

      if (w_m_hs) begin
        r_last_pix <= w_pix;
        r_ocnt     <= r_ocnt + 32'd1;
        if (m_tlast) r_out_done <= 1'b1;
      end

      // Counts the cycles after the start pulse up to and including the
      // final output handshake; sticks at all-ones.
      if (r_ctrl_start) begin
        r_cnt     <= '0;
        r_cnt_run <= 1'b1;
      end else if (r_cnt_run) begin
        if (~&r_cnt) r_cnt <= r_cnt + 1'b1;
        if (w_m_hs && m_tlast) r_cnt_run <= 1'b0;
      end

      case (r_state)
        S_IDLE: if (cfg_start) begin
          r_width     <= cfg_width;
          r_height    <= cfg_height;
          r_total     <= w_total;
          r_rcv       <= '0;
          r_ocnt      <= '0;
          r_in_done   <= 1'b0;
          r_out_done  <= 1'b0;
          r_err_early <= 1'b0;
          r_err_late  <= 1'b0;
          r_err_zero  <= (w_total == 32'd0);
          r_cnt       <= '0;
          r_last_pix  <= {ALPHA_OPAQUE, 24'd0};
          r_state     <= (w_total == 32'd0) ? S_DONE : S_START;
        end
        S_START: if (c_ctrl_ready) begin
          r_ctrl_start <= 1'b1;
          r_state      <= S_STREAM;
        end
        S_STREAM, S_PAD, S_DRAIN: begin
          if (w_s_hs) begin
            if (r_state == S_DRAIN) begin
              if (s_tlast) r_in_done <= 1'b1;
            end else if (w_reached) begin
              if (s_tlast) r_in_done <= 1'b1;
              else begin
                r_err_late <= 1'b1;
                r_state    <= S_DRAIN;
              end
            end else begin
              r_rcv <= r_rcv + 32'(PPB);
              if (s_tlast) begin
                r_err_early <= 1'b1;
                r_in_done   <= 1'b1;
                r_state     <= S_PAD;
              end
            end
          end
          // Both sides finished: the frame is complete.
          if (r_in_done && r_out_done) r_state <= S_DONE;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
